// File: rtl/pacer_fifo.sv
// -----------------------------------------------------------------------------
// pacer_fifo
//
// Small synchronous FIFO used by sample_pacer to absorb bursty upstream samples.
// Storage is a plain array so it can map onto distributed or block RAM.
// The read port is registered: o_data updates on the clock after i_rd.
// The fill count is kept separately with one extra bit.
// This lets the pointers wrap freely while full and empty stay distinct.
//
// Ports:
//   i_clk    clock
//   i_reset  synchronous, active-high reset (pointers, fill, read register)
//   i_wr     write strobe; i_data is stored at the write pointer
//   i_data   write data
//   i_rd     read strobe; o_data <= head entry, read pointer advances
//   o_data   registered read data
//   o_fill   current occupancy, 0..2^LGFIFO
//   o_full   o_fill == 2^LGFIFO
//   o_empty  o_fill == 0
// -----------------------------------------------------------------------------
module pacer_fifo #(
    parameter int IW     = 16,
    parameter int LGFIFO = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr,
    input  logic [IW-1:0]     i_data,
    input  logic              i_rd,
    output logic [IW-1:0]     o_data,
    output logic [LGFIFO:0]   o_fill,
    output logic              o_full,
    output logic              o_empty
);

    localparam logic [LGFIFO:0] DEPTH = (LGFIFO+1)'(2**LGFIFO);

    logic [IW-1:0]     mem_q [2**LGFIFO];
    logic [LGFIFO-1:0] wr_ptr_q;
    logic [LGFIFO-1:0] rd_ptr_q;
    logic [LGFIFO:0]   fill_q;
    logic [LGFIFO:0]   fill_d;
    logic [IW-1:0]     rd_data_q;
    logic              wr_en;
    logic              rd_en;

    // Guard against misuse so the pointers can never overrun each other.
    assign wr_en = i_wr && !o_full;
    assign rd_en = i_rd && !o_empty;

    // NOTE: storage is deliberately not reset; the pointers and fill count decide
    // which entries are meaningful, and a reset on the array would block RAM inference.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    always_comb begin
        fill_d = fill_q;
        case ({wr_en, rd_en})
            2'b10:   fill_d = fill_q + (LGFIFO+1)'(1);
            2'b01:   fill_d = fill_q - (LGFIFO+1)'(1);
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            rd_data_q <= '0;
        end else begin
            fill_q <= fill_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + LGFIFO'(1);
            end
            if (rd_en) begin
                rd_data_q <= mem_q[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + LGFIFO'(1);
            end
        end
    end

    assign o_data  = rd_data_q;
    assign o_fill  = fill_q;
    assign o_full  = (fill_q == DEPTH);
    assign o_empty = (fill_q == '0);

endmodule

// File: rtl/sample_pacer.sv
// -----------------------------------------------------------------------------
// sample_pacer
//
// Upstream feeder for the slow filter family.
// Bursty samples arrive on a valid/ready stream and are buffered in pacer_fifo.
// They are re-emitted as single-cycle clock-enable strobes.
// Consecutive strobes are at least MIN_SPACING clocks apart.
// This honours the filter's idle-cycle requirement between inputs.
// o_ce and o_sample connect straight to the filter's i_ce and i_sample.
//
// Timing: a sample accepted on clock N into an idle, empty block strobes on
// clock N+2. The pop decision happens on N+1 from the registered fill count.
// The FIFO read register and the output register each add one cycle.
//
// Ports:
//   i_clk     clock
//   i_reset   synchronous, active-high reset; discards buffered samples
//   s_valid   upstream sample valid
//   s_ready   block can accept a sample (registered state and i_reset only)
//   s_data    upstream sample
//   o_ce      single-cycle strobe; o_sample is valid this cycle
//   o_sample  paced sample, held between strobes
//   o_fill    FIFO occupancy, 0..2^LGFIFO
//   o_busy    spacing counter nonzero, so no strobe is permitted yet
// -----------------------------------------------------------------------------
module sample_pacer #(
    parameter int IW          = 16,
    parameter int LGFIFO      = 4,
    parameter int MIN_SPACING = 108,
    parameter int LGSPACE     = 7
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [IW-1:0]     s_data,
    output logic              o_ce,
    output logic [IW-1:0]     o_sample,
    output logic [LGFIFO:0]   o_fill,
    output logic              o_busy
);

    // Reload value after a pop. The counter then reaches zero exactly
    // MIN_SPACING-1 clocks later, so the next pop lands MIN_SPACING clocks on.
    localparam logic [LGSPACE-1:0] SPACING_RELOAD = LGSPACE'(MIN_SPACING - 1);

    logic [IW-1:0]      fifo_data;
    logic [LGFIFO:0]    fifo_fill;
    logic               fifo_full;
    logic               fifo_empty;
    logic               wr;
    logic               pop;

    logic [LGSPACE-1:0] cnt_q;
    logic [LGSPACE-1:0] cnt_d;
    logic               pop_q;
    logic               ce_q;
    logic [IW-1:0]      sample_q;

    assign s_ready = !i_reset && !fifo_full;
    assign wr      = s_valid && s_ready;
    assign pop     = !fifo_empty && (cnt_q == '0) && !i_reset;

    pacer_fifo #(
        .IW     (IW),
        .LGFIFO (LGFIFO)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_wr    (wr),
        .i_data  (s_data),
        .i_rd    (pop),
        .o_data  (fifo_data),
        .o_fill  (fifo_fill),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // NOTE: cnt_d takes a default first so every path assigns it and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (pop) begin
            cnt_d = SPACING_RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - LGSPACE'(1);
        end
    end

    // pop_q marks that fifo_data now holds the popped sample. The output
    // register captures it one cycle later, together with the strobe.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q    <= '0;
            pop_q    <= 1'b0;
            ce_q     <= 1'b0;
            sample_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            pop_q <= pop;
            ce_q  <= pop_q;
            if (pop_q) begin
                sample_q <= fifo_data;
            end
        end
    end

    assign o_ce     = ce_q;
    assign o_sample = sample_q;
    assign o_fill   = fifo_fill;
    assign o_busy   = (cnt_q != '0);

endmodule

// File: tb/tb_sample_pacer.sv
// -----------------------------------------------------------------------------
// tb_sample_pacer
//
// Two instances share one stimulus stream:
//   u0: MIN_SPACING=108, the production pacing.
//   u1: MIN_SPACING=1, where a strobe is allowed every cycle.
// A behavioural model tracks, for each instance, the queue of buffered samples
// and the clock of its last pop. From these it derives every output.
// A negedge compare process checks both instances against the model each cycle.
// Directed phases add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_sample_pacer;

    localparam int IW     = 16;
    localparam int LGFIFO = 4;
    localparam int DEPTH  = 16;

    logic            i_clk   = 1'b0;
    logic            i_reset = 1'b1;
    logic            s_valid = 1'b0;
    logic [IW-1:0]   s_data  = '0;

    logic            s_ready0, o_ce0, o_busy0;
    logic [IW-1:0]   o_sample0;
    logic [LGFIFO:0] o_fill0;
    logic            s_ready1, o_ce1, o_busy1;
    logic [IW-1:0]   o_sample1;
    logic [LGFIFO:0] o_fill1;

    always #5 i_clk = ~i_clk;

    sample_pacer #(.IW(IW), .LGFIFO(LGFIFO), .MIN_SPACING(108), .LGSPACE(7)) u0 (
        .i_clk(i_clk), .i_reset(i_reset), .s_valid(s_valid), .s_ready(s_ready0),
        .s_data(s_data), .o_ce(o_ce0), .o_sample(o_sample0), .o_fill(o_fill0),
        .o_busy(o_busy0)
    );

    sample_pacer #(.IW(IW), .LGFIFO(LGFIFO), .MIN_SPACING(1), .LGSPACE(1)) u1 (
        .i_clk(i_clk), .i_reset(i_reset), .s_valid(s_valid), .s_ready(s_ready1),
        .s_data(s_data), .o_ce(o_ce1), .o_sample(o_sample1), .o_fill(o_fill1),
        .o_busy(o_busy1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            cyc = 0;
    bit            m_valid = 1'b0;
    int            m_count [2];
    int            m_head  [2];
    int            m_last  [2];
    bit            m_have  [2];
    bit            m_pend  [2];
    logic [IW-1:0] m_pdata [2];
    logic [IW-1:0] m_buf   [2][64];
    bit            e_ce    [2];
    bit            e_busy  [2];
    logic [IW-1:0] e_sample[2];
    bit            mr_rdy;
    bit            mr_pop;

    function automatic int spacing(input int k);
        return (k == 0) ? 108 : 1;
    endfunction

    // A pop happens when something is buffered and at least `spacing` clocks
    // have passed since the previous pop. Its sample is presented one clock later.
    always @(posedge i_clk) begin
        for (int k = 0; k < 2; k++) begin
            mr_rdy = !i_reset && (m_count[k] < DEPTH);
            if (i_reset) begin
                m_count[k]  = 0;
                m_head[k]   = 0;
                m_have[k]   = 1'b0;
                m_pend[k]   = 1'b0;
                e_ce[k]     = 1'b0;
                e_sample[k] = '0;
            end else begin
                e_ce[k] = m_pend[k];
                if (m_pend[k]) e_sample[k] = m_pdata[k];
                m_pend[k] = 1'b0;
                mr_pop = (m_count[k] > 0) && (!m_have[k] || (cyc - m_last[k] >= spacing(k)));
                if (mr_pop) begin
                    m_pend[k]  = 1'b1;
                    m_pdata[k] = m_buf[k][m_head[k]];
                    m_head[k]  = (m_head[k] + 1) % 64;
                    m_count[k] = m_count[k] - 1;
                    m_last[k]  = cyc;
                    m_have[k]  = 1'b1;
                end
                if (s_valid && mr_rdy) begin
                    m_buf[k][(m_head[k] + m_count[k]) % 64] = s_data;
                    m_count[k] = m_count[k] + 1;
                end
            end
            e_busy[k] = m_have[k] && ((cyc - m_last[k]) < (spacing(k) - 1));
        end
        if (i_reset) m_valid = 1'b1;
        cyc++;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge i_clk) begin
        if (m_valid) begin
            check("ce0",     o_ce0,     e_ce[0]);
            check("sample0", o_sample0, e_sample[0]);
            check("fill0",   o_fill0,   m_count[0]);
            check("busy0",   o_busy0,   e_busy[0]);
            check("ready0",  s_ready0,  !i_reset && (m_count[0] < DEPTH));
            check("ce1",     o_ce1,     e_ce[1]);
            check("sample1", o_sample1, e_sample[1]);
            check("fill1",   o_fill1,   m_count[1]);
            check("busy1",   o_busy1,   e_busy[1]);
            check("ready1",  s_ready1,  !i_reset && (m_count[1] < DEPTH));
        end
    end

    // ---------------- strobe logs for directed checks ----------------
    int            n0 = 0;
    int            n1 = 0;
    int            log0_t [64];
    int            log1_t [64];
    logic [IW-1:0] log0_d [64];
    logic [IW-1:0] log1_d [64];

    always @(negedge i_clk) begin
        if (o_ce0 === 1'b1 && n0 < 64) begin
            log0_t[n0] = cyc;
            log0_d[n0] = o_sample0;
            n0++;
        end
        if (o_ce1 === 1'b1 && n1 < 64) begin
            log1_t[n1] = cyc;
            log1_d[n1] = o_sample1;
            n1++;
        end
    end

    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int sent;
    bit saw_full;
    bit acc;

    initial begin
        // Reset state.
        i_reset = 1'b1;
        step();
        step();
        @(negedge i_clk);
        check("rst_ready0",  s_ready0,  0);
        check("rst_fill0",   o_fill0,   0);
        check("rst_ce0",     o_ce0,     0);
        check("rst_busy0",   o_busy0,   0);
        check("rst_sample0", o_sample0, 0);
        step();
        i_reset = 1'b0;
        @(negedge i_clk);
        check("ready_after_reset", s_ready0, 1);

        // Single sample: the strobe comes two clocks after the accept.
        s_valid = 1'b1;
        s_data  = 16'h1234;
        step();
        s_valid = 1'b0;
        @(negedge i_clk);
        check("single_fill",    o_fill0,    1);
        check("model_fill_pin", m_count[0], 1);
        step();
        @(negedge i_clk);
        check("single_ce_early", o_ce0,   0);
        check("single_fill_pop", o_fill0, 0);
        check("single_busy",     o_busy0, 1);
        step();
        @(negedge i_clk);
        check("single_ce",      o_ce0,     1);
        check("single_sample",  o_sample0, 16'h1234);
        check("model_ce_pin",   e_ce[0],   1);
        step();
        @(negedge i_clk);
        check("single_ce_once", o_ce0, 0);
        idle(120);

        // Burst of 5: strobes exactly 108 clocks apart, data 1..5.
        n0 = 0;
        for (int i = 1; i <= 5; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(i);
            step();
        end
        s_valid = 1'b0;
        idle(600);
        check("burst5_count", n0, 5);
        for (int i = 0; i < 5; i++)
            if (i < n0) check("burst5_data", log0_d[i], i + 1);
        for (int i = 1; i < 5; i++)
            if (i < n0) check("burst5_gap", log0_t[i] - log0_t[i-1], 108);

        // Burst of 20 with s_valid held: fills to 16, then trickles in per pop.
        n0       = 0;
        sent     = 0;
        saw_full = 1'b0;
        s_valid  = 1'b1;
        s_data   = 16'd100;
        for (int c = 0; c < 4000 && sent < 20; c++) begin
            @(negedge i_clk);
            acc = s_ready0;
            if (o_fill0 == 5'd16 && !s_ready0) saw_full = 1'b1;
            step();
            if (acc) begin
                sent++;
                s_data = 16'(100 + sent);
            end
        end
        s_valid = 1'b0;
        check("burst20_sent", sent, 20);
        check("burst20_full_seen", saw_full, 1);
        idle(2300);
        check("burst20_count", n0, 20);
        for (int i = 0; i < 20; i++)
            if (i < n0) check("burst20_order", log0_d[i], 100 + i);

        // MIN_SPACING=1 instance: continuous stream strobes every cycle.
        n1 = 0;
        for (int i = 0; i < 32; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(i);
            step();
        end
        s_valid = 1'b0;
        idle(10);
        check("stream_count", n1, 32);
        for (int i = 0; i < 32; i++)
            if (i < n1) check("stream_data", log1_d[i], i);
        for (int i = 1; i < 32; i++)
            if (i < n1) check("stream_gap", log1_t[i] - log1_t[i-1], 1);

        // Reset mid-operation with 7 buffered and the counter mid-count.
        idle(1800);
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(16'h50 + i);
            step();
        end
        s_valid = 1'b0;
        idle(50);
        @(negedge i_clk);
        check("pre_reset_fill", o_fill0, 7);
        check("pre_reset_busy", o_busy0, 1);
        i_reset = 1'b1;
        @(negedge i_clk);
        check("reset_ready_low", s_ready0, 0);
        step();
        i_reset = 1'b0;
        @(negedge i_clk);
        check("midrst_fill",   o_fill0,   0);
        check("midrst_ce",     o_ce0,     0);
        check("midrst_sample", o_sample0, 0);
        check("midrst_busy",   o_busy0,   0);
        s_valid = 1'b1;
        s_data  = 16'hBEEF;
        step();
        s_valid = 1'b0;
        step();
        @(negedge i_clk);
        check("beef_ce_early", o_ce0, 0);
        step();
        @(negedge i_clk);
        check("beef_ce",     o_ce0,     1);
        check("beef_sample", o_sample0, 16'hBEEF);

        // Idle: nothing arrives, nothing leaves.
        for (int i = 0; i < 500; i++) begin
            step();
            @(negedge i_clk);
            check("idle_ce",    o_ce0,    0);
            check("idle_fill",  o_fill0,  0);
            check("idle_ready", s_ready0, 1);
        end

        // Random traffic with bursty density and occasional resets.
        for (int seg = 0; seg < 15; seg++) begin
            int density;
            density = $urandom_range(5, 95);
            for (int i = 0; i < 200; i++) begin
                s_valid = ($urandom_range(0, 99) < density);
                s_data  = 16'($urandom);
                i_reset = ($urandom_range(0, 399) == 0);
                step();
            end
        end
        i_reset = 1'b0;
        s_valid = 1'b0;
        idle(20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
